// File: rtl/video_filter_sched.sv
// Frame-aware AXI4-Stream scheduler that steers whole frames through a pixel filter or around it.
// Optional frame counter is enabled by defining VIDEO_FILTER_SCHED_FRAME_CNT_EN.
module video_filter_sched #(
  parameter int DATA_WIDTH      = 24,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cfg_mode,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_proc_tdata,
  output logic                  m_proc_tvalid,
  input  logic                  m_proc_tready,
  output logic                  m_proc_tlast,
  output logic                  m_proc_tuser,
  input  logic [DATA_WIDTH-1:0] s_proc_tdata,
  input  logic                  s_proc_tvalid,
  output logic                  s_proc_tready,
  input  logic                  s_proc_tlast,
  input  logic                  s_proc_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  cur_mode,
  output logic                  busy,
  output logic                  err_spurious,
  output logic [15:0]           frame_cnt
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    ST_BYPASS,
    ST_PROC,
    ST_DRAIN
  } state_e;

  state_e                state_q, state_d;
  logic                  curMode_q, curMode_d;
  logic                  target_q, target_d;
  logic [CNT_W-1:0]      outstanding_q, outstanding_d;
  logic                  outFull_q, outFull_d;
  logic [DATA_WIDTH-1:0] outData_q, outData_d;
  logic                  outLast_q, outLast_d;
  logic                  outUser_q, outUser_d;
  logic                  errSpur_q, errSpur_d;

  logic                  loadAllowed, sofSwitch, roomInFilter, loadEn;
  logic                  mprocHs, sprocHs, decOk;
  logic [DATA_WIDTH-1:0] ldData;
  logic                  ldLast, ldUser;

  assign loadAllowed  = !outFull_q || m_axis_tready;
  assign sofSwitch    = s_axis_tvalid && s_axis_tuser && (cfg_mode != curMode_q);
  assign roomInFilter = outstanding_q < CNT_W'(MAX_OUTSTANDING);

  assign m_proc_tdata = s_axis_tdata;
  assign m_proc_tlast = s_axis_tlast;
  assign m_proc_tuser = s_axis_tuser;

  always_comb begin
    state_d       = state_q;
    curMode_d     = curMode_q;
    target_d      = target_q;
    s_axis_tready = 1'b0;
    m_proc_tvalid = 1'b0;
    s_proc_tready = loadAllowed;
    loadEn        = s_proc_tvalid && loadAllowed;
    ldData        = s_proc_tdata;
    ldLast        = s_proc_tlast;
    ldUser        = s_proc_tuser;
    case (state_q)
      ST_BYPASS: begin
        // Stray filter returns are swallowed here, so the output mux takes the input stream.
        s_proc_tready = 1'b1;
        loadEn        = 1'b0;
        ldData        = s_axis_tdata;
        ldLast        = s_axis_tlast;
        ldUser        = s_axis_tuser;
        if (sofSwitch) begin
          target_d = cfg_mode;
          state_d  = ST_DRAIN;
        end else begin
          s_axis_tready = loadAllowed;
          loadEn        = s_axis_tvalid && loadAllowed;
        end
      end
      ST_PROC: begin
        if (sofSwitch) begin
          target_d = cfg_mode;
          state_d  = ST_DRAIN;
        end else begin
          m_proc_tvalid = s_axis_tvalid && roomInFilter;
          s_axis_tready = m_proc_tready && roomInFilter;
        end
      end
      ST_DRAIN: begin
        if (outstanding_q == '0) begin
          curMode_d = target_q;
          state_d   = target_q ? ST_PROC : ST_BYPASS;
        end
      end
      default: state_d = ST_BYPASS;
    endcase
  end

  // A return with an empty counter is flagged and never allowed to wrap it.
  assign mprocHs = m_proc_tvalid && m_proc_tready;
  assign sprocHs = s_proc_tvalid && s_proc_tready;
  assign decOk   = sprocHs && ((outstanding_q != '0) || mprocHs);

  always_comb begin
    outstanding_d = outstanding_q;
    case ({mprocHs, decOk})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
    errSpur_d = errSpur_q || (sprocHs && (outstanding_q == '0) && !mprocHs);
    outFull_d = outFull_q;
    outData_d = outData_q;
    outLast_d = outLast_q;
    outUser_d = outUser_q;
    if (loadEn) begin
      outFull_d = 1'b1;
      outData_d = ldData;
      outLast_d = ldLast;
      outUser_d = ldUser;
    end else if (m_axis_tready) begin
      outFull_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= ST_BYPASS;
      curMode_q     <= 1'b0;
      target_q      <= 1'b0;
      outstanding_q <= '0;
      outFull_q     <= 1'b0;
      outData_q     <= '0;
      outLast_q     <= 1'b0;
      outUser_q     <= 1'b0;
      errSpur_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      curMode_q     <= curMode_d;
      target_q      <= target_d;
      outstanding_q <= outstanding_d;
      outFull_q     <= outFull_d;
      outData_q     <= outData_d;
      outLast_q     <= outLast_d;
      outUser_q     <= outUser_d;
      errSpur_q     <= errSpur_d;
    end
  end

  assign m_axis_tvalid = outFull_q;
  assign m_axis_tdata  = outData_q;
  assign m_axis_tlast  = outLast_q;
  assign m_axis_tuser  = outUser_q;
  assign cur_mode      = curMode_q;
  assign busy          = (state_q == ST_DRAIN);
  assign err_spurious  = errSpur_q;

`ifdef VIDEO_FILTER_SCHED_FRAME_CNT_EN
  logic [15:0] frameCnt_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frameCnt_q <= '0;
    end else if (s_axis_tvalid && s_axis_tready && s_axis_tuser) begin
      frameCnt_q <= frameCnt_q + 16'd1;
    end
  end

  assign frame_cnt = frameCnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_video_filter_sched.sv
// Scoreboard bench for video_filter_sched: an inverting filter model with 3-cycle latency sits on the proc path.
module tb_video_filter_sched;

  localparam int DW = 24;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          user;
    int            cyc;
  } beat_t;

  logic          aclk, aresetn, cfg_mode;
  logic [DW-1:0] s_axis_tdata, m_proc_tdata, s_proc_tdata, m_axis_tdata;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
  logic          m_proc_tvalid, m_proc_tready, m_proc_tlast, m_proc_tuser;
  logic          s_proc_tvalid, s_proc_tready, s_proc_tlast, s_proc_tuser;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic          cur_mode, busy, err_spurious;
  logic [15:0]   frame_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int sofCount = 0;

  beat_t fltQ[$];
  beat_t expQ[$];
  beat_t outQ[$];

  logic          stall = 1'b0;
  logic          spurValid = 1'b0;
  logic          fltValid = 1'b0;
  logic [DW-1:0] fltData = '0;
  logic          fltLast = 1'b0, fltUser = 1'b0;
  logic          holdLow = 1'b0, toggleReady = 1'b0;
  logic          busySeen = 1'b0, procSeen = 1'b0;

  assign s_proc_tvalid = fltValid | spurValid;
  assign s_proc_tdata  = spurValid ? 24'hABCDEF : fltData;
  assign s_proc_tlast  = spurValid ? 1'b0 : fltLast;
  assign s_proc_tuser  = spurValid ? 1'b0 : fltUser;

  video_filter_sched #(.DATA_WIDTH(DW), .MAX_OUTSTANDING(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_mode(cfg_mode),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_proc_tdata(m_proc_tdata), .m_proc_tvalid(m_proc_tvalid), .m_proc_tready(m_proc_tready),
    .m_proc_tlast(m_proc_tlast), .m_proc_tuser(m_proc_tuser),
    .s_proc_tdata(s_proc_tdata), .s_proc_tvalid(s_proc_tvalid), .s_proc_tready(s_proc_tready),
    .s_proc_tlast(s_proc_tlast), .s_proc_tuser(s_proc_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .cur_mode(cur_mode), .busy(busy), .err_spurious(err_spurious), .frame_cnt(frame_cnt)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) cyc <= cyc + 1;

  // Inputs change just after posedge, so values seen at negedge are what the next posedge will act on.
  initial begin : filterModel
    beat_t b;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        fltQ.delete();
      end else begin
        if (fltValid && s_proc_tready && fltQ.size() > 0) b = fltQ.pop_front();
        if (m_proc_tvalid && m_proc_tready) begin
          b.data = ~m_proc_tdata;
          b.last = m_proc_tlast;
          b.user = m_proc_tuser;
          b.cyc  = cyc + 3;
          fltQ.push_back(b);
        end
      end
      @(posedge aclk);
      #1;
      if (!aresetn) fltQ.delete();
      fltValid = 1'b0;
      if (!stall && aresetn && fltQ.size() > 0 && fltQ[0].cyc <= cyc) begin
        fltValid = 1'b1;
        fltData  = fltQ[0].data;
        fltLast  = fltQ[0].last;
        fltUser  = fltQ[0].user;
      end
    end
  end

  initial begin : outMonitor
    beat_t b;
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        if (m_axis_tvalid && m_axis_tready) begin
          b.data = m_axis_tdata;
          b.last = m_axis_tlast;
          b.user = m_axis_tuser;
          b.cyc  = cyc;
          outQ.push_back(b);
        end
        if (busy) busySeen = 1'b1;
        if (m_proc_tvalid) procSeen = 1'b1;
      end
    end
  end

  initial begin : readyDriver
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      if (holdLow) m_axis_tready = 1'b0;
      else if (toggleReady) m_axis_tready = !m_axis_tready;
      else m_axis_tready = 1'b1;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge aclk);
      #1;
    end
  endtask

  // Presents one beat (left asserted on return) and records the expected output once accepted.
  task automatic sendBeat(input logic [DW-1:0] d, input logic l, input logic u, input bit inv,
                          output bit ok, output int waited);
    beat_t b;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    s_axis_tvalid = 1'b1;
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge aclk);
      if (s_axis_tready) begin
        ok = 1'b1;
        b.data = inv ? ~d : d;
        b.last = l;
        b.user = u;
        b.cyc  = cyc;
        expQ.push_back(b);
        if (u) sofCount++;
        break;
      end
      waited++;
    end
    @(posedge aclk);
    #1;
    if (!ok) s_axis_tvalid = 1'b0;
  endtask

  task automatic waitOutputs(input int n, output bit ok);
    for (int i = 0; i < 1000; i++) begin
      if (outQ.size() >= n) break;
      @(posedge aclk);
      #1;
    end
    ok = (outQ.size() >= n);
  endtask

  function automatic logic [15:0] expFrameCnt();
`ifdef VIDEO_FILTER_SCHED_FRAME_CNT_EN
    return 16'(sofCount);
`else
    return 16'd0;
`endif
  endfunction

  task automatic test_reset();
    aresetn = 1'b0;
    waitCycles(3);
    checks++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser} !== {1'b0, 24'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_out: got valid=%b data=%h last=%b user=%b, want all zero",
               m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser);
    end
    checks++;
    if ({cur_mode, busy, err_spurious, m_proc_tvalid} !== 4'b0000 || frame_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_status: got mode=%b busy=%b err=%b mproc_valid=%b fcnt=%0d, want 0",
               cur_mode, busy, err_spurious, m_proc_tvalid, frame_cnt);
    end
    aresetn = 1'b1;
    waitCycles(2);
  endtask

  task automatic test_bypass();
    bit ok, allOk;
    int w;
    beat_t o, e;
    allOk = 1'b1;
    cfg_mode = 1'b0;
    procSeen = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      sendBeat(DW'(i), i == 8, i == 1, 1'b0, ok, w);
      allOk &= ok;
    end
    s_axis_tvalid = 1'b0;
    checks++;
    if (!allOk) begin failures++; $display("FAIL bypass_accept: got a timeout, required all 8 accepted"); end
    waitOutputs(8, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bypass_count: got %0d outputs, want 8", outQ.size()); end
    while (outQ.size() > 0 && expQ.size() > 0) begin
      o = outQ.pop_front();
      e = expQ.pop_front();
      checks++;
      if ({o.data, o.last, o.user} !== {e.data, e.last, e.user} || (o.cyc - e.cyc) != 1) begin
        failures++;
        $display("FAIL bypass_beat: got data=%h last=%b user=%b lat=%0d, want data=%h last=%b user=%b lat=1",
                 o.data, o.last, o.user, o.cyc - e.cyc, e.data, e.last, e.user);
      end
    end
    checks++;
    if (procSeen !== 1'b0) begin failures++; $display("FAIL bypass_mproc: got m_proc_tvalid=1, want never high"); end
    checks++;
    if (frame_cnt !== expFrameCnt()) begin
      failures++;
      $display("FAIL bypass_fcnt: got %0d, want %0d", frame_cnt, expFrameCnt());
    end
  endtask

  task automatic test_mode_switch();
    bit ok, allOk;
    int w, sofWait;
    beat_t o, e;
    logic [DW-1:0] pix[4];
    pix[0] = 24'h123456; pix[1] = 24'h0000AA; pix[2] = 24'h00FF00; pix[3] = 24'hF0F0F0;
    cfg_mode = 1'b1;
    busySeen = 1'b0;
    allOk = 1'b1;
    sendBeat(pix[0], 1'b0, 1'b1, 1'b1, ok, sofWait);
    allOk &= ok;
    for (int i = 1; i < 4; i++) begin
      sendBeat(pix[i], i == 3, 1'b0, 1'b1, ok, w);
      allOk &= ok;
    end
    s_axis_tvalid = 1'b0;
    checks++;
    if (!allOk || sofWait < 2) begin
      failures++;
      $display("FAIL switch_sof_hold: got accepted=%b wait=%0d, want accepted=1 wait>=2", allOk, sofWait);
    end
    checks++;
    if (busySeen !== 1'b1) begin failures++; $display("FAIL switch_busy: got busy never high, want high in drain"); end
    waitOutputs(4, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL switch_count: got %0d outputs, want 4", outQ.size()); end
    while (outQ.size() > 0 && expQ.size() > 0) begin
      o = outQ.pop_front();
      e = expQ.pop_front();
      checks++;
      if ({o.data, o.last, o.user} !== {e.data, e.last, e.user}) begin
        failures++;
        $display("FAIL switch_beat: got data=%h last=%b user=%b, want data=%h last=%b user=%b",
                 o.data, o.last, o.user, e.data, e.last, e.user);
      end
    end
    checks++;
    if (cur_mode !== 1'b1) begin failures++; $display("FAIL switch_mode: got cur_mode=%b, want 1", cur_mode); end
  endtask

  task automatic test_stall();
    bit ok, allOk, blocked;
    int w;
    beat_t o, e;
    stall = 1'b1;
    allOk = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sendBeat(24'h200000 + DW'(i), 1'b0, i == 0, 1'b1, ok, w);
      allOk &= ok;
    end
    checks++;
    if (!allOk) begin failures++; $display("FAIL stall_first16: got a timeout, want 16 accepted"); end
    s_axis_tdata = 24'h200010;
    s_axis_tlast = 1'b0;
    s_axis_tuser = 1'b0;
    s_axis_tvalid = 1'b1;
    blocked = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      if (s_axis_tready) blocked = 1'b0;
    end
    @(posedge aclk);
    #1;
    checks++;
    if (blocked !== 1'b1) begin failures++; $display("FAIL stall_cap: got s_axis_tready=1 at 16 in flight, want 0"); end
    stall = 1'b0;
    sendBeat(24'h200010, 1'b0, 1'b0, 1'b1, ok, w);
    checks++;
    if (!ok) begin failures++; $display("FAIL stall_resume: got no accept after release, want accept"); end
    for (int i = 17; i < 20; i++) begin
      sendBeat(24'h200000 + DW'(i), i == 19, 1'b0, 1'b1, ok, w);
    end
    s_axis_tvalid = 1'b0;
    waitOutputs(20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL stall_count: got %0d outputs, want 20", outQ.size()); end
    while (outQ.size() > 0 && expQ.size() > 0) begin
      o = outQ.pop_front();
      e = expQ.pop_front();
      checks++;
      if ({o.data, o.last, o.user} !== {e.data, e.last, e.user}) begin
        failures++;
        $display("FAIL stall_beat: got data=%h last=%b user=%b, want data=%h last=%b user=%b",
                 o.data, o.last, o.user, e.data, e.last, e.user);
      end
    end
  endtask

  task automatic test_drain_switch();
    bit ok, busyHeld, tready0, modeHeld;
    int w;
    beat_t o, e;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sendBeat(24'h300000 + DW'(i), i == 4, i == 0, 1'b1, ok, w);
    end
    cfg_mode = 1'b0;
    s_axis_tdata = 24'h400001;
    s_axis_tlast = 1'b0;
    s_axis_tuser = 1'b1;
    s_axis_tvalid = 1'b1;
    busyHeld = 1'b1;
    tready0 = 1'b1;
    modeHeld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      if (s_axis_tready) tready0 = 1'b0;
      if (i > 0 && !busy) busyHeld = 1'b0;
      if (cur_mode !== 1'b1) modeHeld = 1'b0;
    end
    @(posedge aclk);
    #1;
    checks++;
    if ({busyHeld, tready0, modeHeld} !== 3'b111) begin
      failures++;
      $display("FAIL drain_hold: got busy=%b sof_blocked=%b mode_kept=%b, want 1 1 1", busyHeld, tready0, modeHeld);
    end
    stall = 1'b0;
    sendBeat(24'h400001, 1'b0, 1'b1, 1'b0, ok, w);
    checks++;
    if (!ok) begin failures++; $display("FAIL drain_exit: got SOF never accepted, want accept after drain"); end
    sendBeat(24'h400002, 1'b0, 1'b0, 1'b0, ok, w);
    sendBeat(24'h400003, 1'b1, 1'b0, 1'b0, ok, w);
    s_axis_tvalid = 1'b0;
    waitOutputs(8, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL drain_count: got %0d outputs, want 8", outQ.size()); end
    while (outQ.size() > 0 && expQ.size() > 0) begin
      o = outQ.pop_front();
      e = expQ.pop_front();
      checks++;
      if ({o.data, o.last, o.user} !== {e.data, e.last, e.user}) begin
        failures++;
        $display("FAIL drain_beat: got data=%h last=%b user=%b, want data=%h last=%b user=%b",
                 o.data, o.last, o.user, e.data, e.last, e.user);
      end
    end
    checks++;
    if ({cur_mode, busy} !== 2'b00) begin
      failures++;
      $display("FAIL drain_final: got cur_mode=%b busy=%b, want 0 0", cur_mode, busy);
    end
  endtask

  task automatic test_back_to_back();
    bit ok, allOk;
    int w;
    beat_t o, e;
    toggleReady = 1'b1;
    allOk = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      if (i == 10) cfg_mode = 1'b1;
      if (i == 20) cfg_mode = 1'b0;
      sendBeat(24'h500000 + DW'(i), i == 32, i == 1, 1'b0, ok, w);
      allOk &= ok;
    end
    s_axis_tvalid = 1'b0;
    checks++;
    if (!allOk) begin failures++; $display("FAIL toggle_accept: got a timeout, want 32 accepted"); end
    waitOutputs(32, ok);
    toggleReady = 1'b0;
    waitCycles(6);
    checks++;
    if (outQ.size() != 32) begin failures++; $display("FAIL toggle_count: got %0d outputs, want 32", outQ.size()); end
    while (outQ.size() > 0 && expQ.size() > 0) begin
      o = outQ.pop_front();
      e = expQ.pop_front();
      checks++;
      if ({o.data, o.last, o.user} !== {e.data, e.last, e.user}) begin
        failures++;
        $display("FAIL toggle_beat: got data=%h last=%b user=%b, want data=%h last=%b user=%b",
                 o.data, o.last, o.user, e.data, e.last, e.user);
      end
    end
    checks++;
    if (cur_mode !== 1'b0) begin failures++; $display("FAIL toggle_midframe_cfg: got cur_mode=%b, want 0", cur_mode); end
  endtask

  task automatic test_spurious_reset();
    bit ok;
    int w;
    spurValid = 1'b1;
    waitCycles(1);
    spurValid = 1'b0;
    @(negedge aclk);
    checks++;
    if ({err_spurious, m_axis_tvalid} !== 2'b10 || outQ.size() != 0) begin
      failures++;
      $display("FAIL spurious_flag: got err=%b out_valid=%b outs=%0d, want err=1 out_valid=0 outs=0",
               err_spurious, m_axis_tvalid, outQ.size());
    end
    @(posedge aclk);
    #1;
    holdLow = 1'b1;
    cfg_mode = 1'b1;
    waitCycles(2);
    sendBeat(24'h600001, 1'b0, 1'b1, 1'b1, ok, w);
    sendBeat(24'h600002, 1'b0, 1'b0, 1'b1, ok, w);
    s_axis_tvalid = 1'b0;
    waitCycles(6);
    checks++;
    if ({m_axis_tvalid, cur_mode, err_spurious} !== 3'b111) begin
      failures++;
      $display("FAIL spurious_sticky: got out_valid=%b mode=%b err=%b, want 1 1 1", m_axis_tvalid, cur_mode, err_spurious);
    end
    @(negedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    checks++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser} !== {1'b0, 24'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL midframe_reset_out: got valid=%b data=%h last=%b user=%b, want all zero",
               m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser);
    end
    checks++;
    if ({cur_mode, busy, err_spurious, m_proc_tvalid} !== 4'b0000 || frame_cnt !== 16'd0) begin
      failures++;
      $display("FAIL midframe_reset_status: got mode=%b busy=%b err=%b mproc_valid=%b fcnt=%0d, want 0",
               cur_mode, busy, err_spurious, m_proc_tvalid, frame_cnt);
    end
    expQ.delete();
    outQ.delete();
    sofCount = 0;
    holdLow = 1'b0;
    cfg_mode = 1'b0;
    waitCycles(2);
    aresetn = 1'b1;
    waitCycles(2);
  endtask

  initial begin
    aresetn = 1'b0;
    cfg_mode = 1'b0;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tuser = 1'b0;
    m_proc_tready = 1'b1;
    #1;
    test_reset();
    test_bypass();
    test_mode_switch();
    test_stall();
    test_drain_switch();
    test_back_to_back();
    test_spurious_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
